// File: rtl/shift_rx_ctrl.sv
// Serial-to-parallel receiver: gathers 8 LSB-first bits per frame and holds the
// word for a consumer handshake. Reports bit-gap timeouts and overruns.
module shift_rx_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       SRC_CLK,
    input  logic       SRC_RST,
    input  logic       SRC_START,
    input  logic       SRC_BIT_EN,
    input  logic       SRC_SER_IN,
    input  logic       SRC_ACK,
    output logic [7:0] SRC_DATA_O,
    output logic       SRC_VALID,
    output logic       SRC_BUSY,
    output logic [3:0] SRC_BIT_CNT,
    output logic       SRC_ERR,
    output logic       SRC_OVR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Abort fires when the gap count already equals TIMEOUT-1 and another gap cycle arrives.
    localparam logic [7:0] GAP_LIMIT   = 8'(TIMEOUT - 1);
    localparam bit         TIMEOUT_ON  = (TIMEOUT != 0);

    state_t     state, state_n;
    logic [7:0] sr, sr_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] gap, gap_n;
    logic [7:0] data, data_n;
    logic       valid, valid_n;
    logic       err, err_n;
    logic       ovr, ovr_n;
    logic [7:0] shifted;

    assign shifted = {SRC_SER_IN, sr[7:1]};

    always_ff @(posedge SRC_CLK) begin
        if (SRC_RST) begin
            state   <= IDLE;
            sr      <= 8'h00;
            bit_cnt <= 4'd0;
            gap     <= 8'h00;
            data    <= 8'h00;
            valid   <= 1'b0;
            err     <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            bit_cnt <= bit_cnt_n;
            gap     <= gap_n;
            data    <= data_n;
            valid   <= valid_n;
            err     <= err_n;
            ovr     <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        bit_cnt_n = bit_cnt;
        gap_n     = gap;
        data_n    = data;
        valid_n   = valid;
        err_n     = 1'b0;
        ovr_n     = ovr;

        case (state)
            IDLE: begin
                bit_cnt_n = 4'd0;
                if (SRC_START) begin
                    state_n = SHIFT;
                    sr_n    = 8'h00;
                    gap_n   = 8'h00;
                end
            end

            SHIFT: begin
                // A restart wins over a strobe arriving in the same cycle.
                if (SRC_START) begin
                    sr_n      = 8'h00;
                    bit_cnt_n = 4'd0;
                    gap_n     = 8'h00;
                end else if (SRC_BIT_EN) begin
                    sr_n      = shifted;
                    bit_cnt_n = bit_cnt + 4'd1;
                    gap_n     = 8'h00;
                    if (bit_cnt == 4'd7) begin
                        data_n  = shifted;
                        valid_n = 1'b1;
                        state_n = DONE;
                    end
                end else if (TIMEOUT_ON && (gap == GAP_LIMIT)) begin
                    state_n   = IDLE;
                    err_n     = 1'b1;
                    bit_cnt_n = 4'd0;
                    gap_n     = 8'h00;
                end else if (gap != 8'hFF) begin
                    gap_n = gap + 8'd1;
                end
            end

            DONE: begin
                if (SRC_ACK) begin
                    valid_n = 1'b0;
                    if (SRC_START) begin
                        state_n   = SHIFT;
                        sr_n      = 8'h00;
                        bit_cnt_n = 4'd0;
                        gap_n     = 8'h00;
                    end else begin
                        state_n   = IDLE;
                        bit_cnt_n = 4'd0;
                    end
                end else if (SRC_START) begin
                    ovr_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign SRC_DATA_O  = data;
    assign SRC_VALID   = valid;
    assign SRC_BUSY    = (state == SHIFT);
    assign SRC_BIT_CNT = bit_cnt;
    assign SRC_ERR     = err;
    assign SRC_OVR     = ovr;

endmodule

// File: tb/tb_shift_rx_ctrl.sv
// Self-checking bench for shift_rx_ctrl: directed frames followed by random
// traffic, every cycle compared against a queue-based frame model.
module tb_shift_rx_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst, start, bit_en, ser_in, ack;
    logic [7:0] data_o;
    logic       valid, busy, err, ovr;
    logic [3:0] bit_cnt;

    int errCount   = 0;
    int checkCount = 0;
    bit errSeen    = 0;

    // Reference model: a frame is a list of received bits, the word is their weighted sum.
    bit   inFrame, holding;
    bit   rxBits[$];
    int   idleRun;
    int   mData;
    bit   mValid, mErr, mOvr;

    shift_rx_ctrl #(.TIMEOUT(TMO)) dut (
        .SRC_CLK     (clk),
        .SRC_RST     (rst),
        .SRC_START   (start),
        .SRC_BIT_EN  (bit_en),
        .SRC_SER_IN  (ser_in),
        .SRC_ACK     (ack),
        .SRC_DATA_O  (data_o),
        .SRC_VALID   (valid),
        .SRC_BUSY    (busy),
        .SRC_BIT_CNT (bit_cnt),
        .SRC_ERR     (err),
        .SRC_OVR     (ovr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit s, input bit e, input bit d, input bit a);
        bit newErr = 0;
        int word;
        if (r) begin
            inFrame = 0; holding = 0; rxBits.delete(); idleRun = 0;
            mData = 0; mValid = 0; mOvr = 0;
        end else if (inFrame) begin
            if (s) begin
                rxBits.delete(); idleRun = 0;
            end else if (e) begin
                rxBits.push_back(d); idleRun = 0;
                if (rxBits.size() == 8) begin
                    word = 0;
                    foreach (rxBits[i]) word += int'(rxBits[i]) * (1 << i);
                    mData = word; mValid = 1; inFrame = 0; holding = 1;
                    rxBits.delete();
                end
            end else begin
                idleRun++;
                if (idleRun == TMO) begin
                    inFrame = 0; rxBits.delete(); idleRun = 0; newErr = 1;
                end
            end
        end else if (holding) begin
            if (a) begin
                mValid = 0; holding = 0;
                if (s) begin
                    inFrame = 1; rxBits.delete(); idleRun = 0;
                end
            end else if (s) begin
                mOvr = 1;
            end
        end else if (s) begin
            inFrame = 1; rxBits.delete(); idleRun = 0;
        end
        mErr = newErr;
    endtask

    // One clock of stimulus, then every output compared with the model.
    task automatic applyStimulus(input bit s, input bit e, input bit d, input bit a, input bit r);
        int expCnt;
        rst = r; start = s; bit_en = e; ser_in = d; ack = a;
        @(posedge clk);
        modelStep(r, s, e, d, a);
        #1;
        expCnt = inFrame ? rxBits.size() : (holding ? 8 : 0);
        if (err) errSeen = 1;
        checkOutput("data",    int'(data_o),  mData);
        checkOutput("valid",   int'(valid),   int'(mValid));
        checkOutput("busy",    int'(busy),    int'(inFrame));
        checkOutput("bit_cnt", int'(bit_cnt), expCnt);
        checkOutput("err",     int'(err),     int'(mErr));
        checkOutput("ovr",     int'(ovr),     int'(mOvr));
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, b[i], 0, 0);
    endtask

    initial begin
        logic [7:0] pattern;
        rst = 1; start = 0; bit_en = 0; ser_in = 0; ack = 0;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_busy",  int'(busy),  0);

        // Bits 1,0,1,0,0,1,0,1 assemble to 0xA5.
        applyStimulus(1, 0, 0, 0, 0);
        pattern = 8'hA5;
        sendByte(pattern);
        checkOutput("a5_data",  int'(data_o),  8'hA5);
        checkOutput("a5_valid", int'(valid),   1);
        checkOutput("a5_cnt",   int'(bit_cnt), 8);
        checkOutput("a5_busy",  int'(busy),    0);
        applyStimulus(0, 0, 0, 1, 0);

        // Timeout: 3 bits then 4 gap cycles aborts, error pulses once.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("tmo_err",  int'(err),    1);
        checkOutput("tmo_busy", int'(busy),   0);
        checkOutput("tmo_data", int'(data_o), 8'hA5);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("tmo_err_once", int'(err), 0);

        // Overrun while holding 0x3C.
        applyStimulus(1, 0, 0, 0, 0);
        pattern = 8'h3C;
        sendByte(pattern);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("ovr_set",   int'(ovr),    1);
        checkOutput("ovr_data",  int'(data_o), 8'h3C);
        checkOutput("ovr_valid", int'(valid),  1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("ovr_ack_valid", int'(valid), 0);
        checkOutput("ovr_sticky",    int'(ovr),   1);
        applyStimulus(0, 0, 0, 0, 1);

        // Back-to-back: ACK+START while holding 0xFF, then 0x01.
        applyStimulus(1, 0, 0, 0, 0);
        pattern = 8'hFF;
        sendByte(pattern);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("b2b_valid_low", int'(valid), 0);
        checkOutput("b2b_busy",      int'(busy),  1);
        pattern = 8'h01;
        sendByte(pattern);
        checkOutput("b2b_data", int'(data_o), 8'h01);
        checkOutput("b2b_ovr",  int'(ovr),    0);
        applyStimulus(0, 0, 0, 1, 0);

        // Reset mid-frame discards it; later strobes without START are ignored.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rst_data", int'(data_o),  0);
        checkOutput("rst_cnt",  int'(bit_cnt), 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, 0);
        checkOutput("rst_no_valid", int'(valid), 0);

        // Restart in mid-frame, then 0x81 with no error.
        errSeen = 0;
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        pattern = 8'h81;
        sendByte(pattern);
        checkOutput("restart_data", int'(data_o), 8'h81);
        checkOutput("restart_err",  int'(errSeen), 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Random traffic with occasional quiet stretches to provoke timeouts.
        for (int n = 0; n < 3000; n++) begin
            bit rs, ss, es, ds, as;
            rs = ($urandom_range(0, 199) == 0);
            ss = ($urandom_range(0, 15) == 0);
            es = ((n / 40) % 3 == 2) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            ds = $urandom_range(0, 1);
            as = ($urandom_range(0, 3) == 0);
            applyStimulus(ss, es, ds, as, rs);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/shift_rx_ctrl.md
SHIFT_RX_CTRL -- requirements
Module: shift_rx_ctrl

Interface
REQ-001 The block SHALL have exactly one parameter: TIMEOUT, default 255, meaning the number of consecutive bit-gap cycles in SHIFT that abort a frame; the range is 0..255 and 0 disables the timeout.
REQ-002 SRC_CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 SRC_RST  input  1  reset, synchronous, active-high.
REQ-004 SRC_START  input  1  frame-start request.
REQ-005 SRC_BIT_EN  input  1  bit strobe; SRC_SER_IN is sampled when high.
REQ-006 SRC_SER_IN  input  1  serial data, LSB first.
REQ-007 SRC_ACK  input  1  consumer accepts SRC_DATA_O.
REQ-008 SRC_DATA_O  output  8  last completed parallel word.
REQ-009 SRC_VALID  output  1  SRC_DATA_O holds an unacknowledged word.
REQ-010 SRC_BUSY  output  1  high in SHIFT state.
REQ-011 SRC_BIT_CNT  output  4  number of bits shifted in the current frame (0..8).
REQ-012 SRC_ERR  output  1  one-cycle pulse on timeout abort.
REQ-013 SRC_OVR  output  1  sticky overrun flag.

Function
REQ-014 The block SHALL contain an internal 8-bit right-shift register SR; each accepted bit SHALL load SR <= {SRC_SER_IN, SR[7:1]}, so the first bit received ends in bit 0 after 8 shifts.
REQ-015 The FSM SHALL have exactly the states IDLE, SHIFT and DONE; the reset state is IDLE.
REQ-016 IDLE: SRC_START=1 SHALL move to SHIFT and clear SR, SRC_BIT_CNT and the gap counter; SRC_BIT_EN SHALL be ignored in IDLE.
REQ-017 SHIFT: each cycle with SRC_BIT_EN=1 SHALL shift one bit, increment SRC_BIT_CNT and clear the gap counter.
REQ-018 SHIFT: the 8th accepted bit SHALL load SRC_DATA_O with {SRC_SER_IN, SR[7:1]}, set SRC_VALID, and move to DONE; all take effect on the same edge, so SRC_VALID rises on the cycle after the 8th strobe.
REQ-019 SHIFT: SRC_START=1 SHALL restart the frame (SR, count and gap counter cleared, state stays SHIFT); any SRC_BIT_EN in that cycle SHALL be discarded, and no SRC_ERR is raised.
REQ-020 SHIFT timeout (TIMEOUT>0): the TIMEOUT-th consecutive cycle in SHIFT with SRC_BIT_EN=0 SHALL abort to IDLE; SRC_ERR=1 for exactly the following cycle.
REQ-021 SHIFT timeout: the gap counter SHALL be 8 bits; the first SHIFT cycle after START counts as a gap cycle; SRC_DATA_O and SRC_VALID SHALL be unchanged by the abort.
REQ-022 SRC_BIT_CNT SHALL hold 8 in DONE, and SHALL read 0 in IDLE.
REQ-023 DONE: SRC_VALID SHALL stay 1 and SRC_DATA_O stable until SRC_ACK=1.
REQ-024 DONE: SRC_ACK=1 SHALL clear SRC_VALID on the next edge and go to IDLE.
REQ-025 DONE: SRC_ACK=1 together with SRC_START=1 SHALL clear SRC_VALID and go directly to SHIFT (back-to-back frame, no overrun).
REQ-026 DONE: SRC_START=1 without SRC_ACK SHALL be ignored and SHALL set SRC_OVR, which stays 1 until reset.
REQ-027 SRC_ACK while SRC_VALID=0 SHALL have no effect.
REQ-028 SRC_DATA_O SHALL retain the last completed word after acknowledge until the next frame completes.
REQ-029 SRC_BUSY SHALL equal (state==SHIFT) and SHALL be registered state, not a function of inputs.

Reset
REQ-030 SRC_RST=1 at a clock edge SHALL force IDLE, SR=0x00, SRC_DATA_O=0x00, SRC_VALID=0, SRC_BUSY=0, SRC_BIT_CNT=0, SRC_ERR=0, SRC_OVR=0, and gap counter=0, from any state.
REQ-031 SRC_RST SHALL take priority over all other inputs in the same cycle; a frame in progress SHALL be discarded.

Verification
REQ-032 START, then 8 strobes with bits 1,0,1,0,0,1,0,1 -> SRC_VALID=1 the next cycle, SRC_DATA_O=0xA5, SRC_BIT_CNT=8, SRC_BUSY=0.
REQ-033 TIMEOUT=4: START, 3 bits, then 4 idle cycles -> IDLE, SRC_ERR high for 1 cycle, SRC_VALID and SRC_DATA_O unchanged.
REQ-034 Frame 0x3C completes; hold SRC_ACK=0 and pulse START -> SRC_OVR=1, SRC_VALID=1, SRC_DATA_O=0x3C; then ACK -> SRC_VALID=0, SRC_OVR stays 1.
REQ-035 Frame 0xFF completes; ACK and START in the same cycle, then bits for 0x01 -> SRC_VALID pulses low for one or more cycles, second word 0x01, SRC_OVR=0.
REQ-036 START, then 5 bits, then SRC_RST for one cycle -> all outputs zero; 8 following strobes without START produce no SRC_VALID.
REQ-037 START, then 4 bits, then START again, then 8 bits of 0x81 -> SRC_DATA_O=0x81, SRC_ERR never asserted.
